// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer handshake and status bundle for sync_fifo
interface sync_fifo_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
  modport master (output wr_data, wr_en, rd_en, input rd_data, full, empty);
  modport slave  (input wr_data, wr_en, rd_en, output rd_data, full, empty);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers and a registered read port
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input logic        clk,
  input logic        rst_n,
  sync_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_acc, rd_acc;
  // MSB is the wrap bit: equal low bits with differing wraps means full
  assign bus.empty = wr_ptr_q == rd_ptr_q;
  assign bus.full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign bus.rd_data = rd_data_q;
  assign wr_acc = bus.wr_en && !bus.full;
  assign rd_acc = bus.rd_en && !bus.empty;
  always_comb begin
    wr_ptr_d  = wr_acc ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d  = rd_acc ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    rd_data_d = rd_acc ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed stimulus checked against a queue-based FIFO model
module tb_sync_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_rd = '0;
  sync_fifo_if #(.DATA_WIDTH(DW)) bus ();
  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".rd_data"}, bus.rd_data, exp_rd);
    check({tag, ".empty"}, DW'(bus.empty), DW'(q.size() == 0));
    check({tag, ".full"}, DW'(bus.full), DW'(q.size() == DEPTH));
  endtask
  task automatic step(input string tag, input logic we, input logic re, input logic [DW-1:0] d);
    bit w_ok, r_ok;
    bus.wr_en = we;
    bus.rd_en = re;
    bus.wr_data = d;
    @(posedge clk);
    w_ok = we && q.size() < DEPTH;
    r_ok = re && q.size() != 0;
    if (r_ok) exp_rd = q.pop_front();
    if (w_ok) q.push_back(d);
    #1;
    check_all(tag);
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    #20;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) step("fill", 1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 17; i++) step("drain", 1'b0, 1'b1, '0);
    check("underflow_hold", bus.rd_data, 32'h0000000F);
    for (int i = 0; i < 10; i++) step("wrap_w10", 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 10; i++) step("wrap_r10", 1'b0, 1'b1, '0);
    for (int i = 0; i < 16; i++) step("wrap_wA", 1'b1, 1'b0, DW'(32'hA0 + i));
    check("wrap_full", DW'(bus.full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step("wrap_rA", 1'b0, 1'b1, '0);
      check("wrap_order", bus.rd_data, DW'(32'hA0 + i));
    end
    for (int i = 0; i < 5; i++) step("occ5_w", 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 8; i++) step("occ5_both", 1'b1, 1'b1, $urandom);
    for (int i = 0; i < 5; i++) step("occ5_r", 1'b0, 1'b1, '0);
    check("occ5_empty", DW'(bus.empty), 32'd1);
    step("empty_both", 1'b1, 1'b1, 32'h1234_5678);
    step("empty_both_r", 1'b0, 1'b1, '0);
    check("empty_both_data", bus.rd_data, 32'h1234_5678);
    for (int i = 0; i < DEPTH; i++) step("full_w", 1'b1, 1'b0, DW'(32'hF00 + i));
    step("full_both", 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("full_both_data", bus.rd_data, 32'h0000_0F00);
    for (int i = 0; i < DEPTH; i++) step("full_drain", 1'b0, 1'b1, '0);
    check("full_both_rejected", bus.rd_data, 32'h0000_0F0F);
    for (int i = 0; i < 400; i++)
      step("random", ($urandom % 3) != 0, ($urandom % 3) != 0, $urandom);
    for (int i = 0; i < DEPTH + 1; i++) step("rnd_drain", 1'b0, 1'b1, '0);
    for (int i = 0; i < 8; i++) step("mid_w", 1'b1, 1'b0, $urandom);
    bus.wr_en = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_rd = '0;
    check_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_w", 1'b1, 1'b0, 32'h55);
    step("post_r", 1'b0, 1'b1, '0);
    check("post_data", bus.rd_data, 32'h55);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in first-out buffer with a parameterised word width and depth, full/empty status flags and a registered read port. It decouples a producer and consumer running on the same clock, for example between packet validation and sorting stages. Writes into a full FIFO and reads from an empty FIFO are ignored without corrupting state.

## Interface
- `DATA_WIDTH`, default 32: word width in bits.
- `FIFO_DEPTH`, default 16: number of storage entries. Must be a power of two and ≥ 2.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `wr_data` input DATA_WIDTH: write word, sampled when a write is accepted.
- `wr_en` input 1: write request, sampled at the rising edge.
- `rd_en` input 1: read request, sampled at the rising edge.
- `rd_data` output DATA_WIDTH: registered read word.
- `full` output 1: high when FIFO_DEPTH entries are stored.
- `empty` output 1: high when zero entries are stored.

## Operation
- Storage: array of FIFO_DEPTH words. The array is not reset.
- Pointers: write and read pointers of width log2(FIFO_DEPTH)+1 bits.
  - The low bits index the array.
  - The MSB is a wrap bit, toggled each pass through the array.
- Flags are combinational from the registered pointers.
  - `empty` = (wr_ptr == rd_ptr).
  - `full` = low bits equal AND MSBs differ.
- Write accepted (`wr_acc`) = `wr_en` & !`full`.
  - On acceptance: mem[wr_ptr low bits] <= `wr_data`; wr_ptr increments.
- Read accepted (`rd_acc`) = `rd_en` & !`empty`.
  - On acceptance: `rd_data` <= mem[rd_ptr low bits]; rd_ptr increments.
- Rejected requests change nothing. `rd_data` holds its last value when no read is accepted.
- Flags are evaluated on pre-edge pointer values, so:
  - Simultaneous write and read while empty: the write is accepted and the read is rejected.
  - Simultaneous write and read while full: the read is accepted and the write is rejected.
  - Simultaneous write and read otherwise: both are accepted and the occupancy is unchanged.
- Pointers wrap modulo 2×FIFO_DEPTH naturally, so order is preserved across wrap-around.
- Data is returned strictly in write order.

## Timing
- While `rst_n` = 0, asynchronously:
  - wr_ptr = 0 and rd_ptr = 0.
  - `rd_data` = 0.
  - `empty` = 1 and `full` = 0.
  - Any in-flight request is discarded.
- Reset mid-operation: all stored entries are logically lost. After release the FIFO is empty.
- Write to flag latency: one edge.
  - A write accepted at edge N makes `empty` low after edge N.
  - The FIFO_DEPTH-th outstanding write makes `full` high after its edge.
- Read latency: one edge. A read accepted at edge N presents its word on `rd_data` after edge N (registered, not fall-through).
- `rd_en` held high across consecutive edges reads one word per edge until `empty`.
- Flags deassert one edge after the opposing operation: `full` drops after a read, `empty` drops after a write.

## Test plan
- Reset check: assert `rst_n` = 0 for 20 ns, then release.
  - Expect `empty` = 1, `full` = 0, `rd_data` = 0.
- Fill and overflow, depth 16: attempt to write 0..31 on consecutive edges.
  - Only 0x0..0xF are accepted.
  - `full` goes high after the 16th write.
  - Later writes are ignored and the pointers are unchanged.
- Drain and underflow: read 16 times.
  - `rd_data` returns 0x0..0xF in order.
  - `empty` goes high after the 16th read.
  - A 17th read leaves `rd_data` = 0xF.
- Wrap-around: write 10 words, read 10, then write 16 words A0..AF and read 16.
  - Reads return A0..AF in order.
  - `full` and `empty` are correct throughout.
- Simultaneous access:
  - Hold `wr_en` = `rd_en` = 1 at occupancy 5: occupancy stays 5 and data stays in order.
  - At empty: only the write is accepted.
  - At full: only the read is accepted.
- Reset mid-operation: write 8 words, pulse `rst_n` low asynchronously between edges.
  - Expect immediately `empty` = 1 and `rd_data` = 0.
  - A subsequent write/read of 0x55 returns 0x55.
